fir_sm_out: RTL and testbench

FIR_SM_OUT -- requirements
Module: fir_sm_out

---
 rtl/fir_sm_out.sv | 114 +++++++++++
 tb/tb_fir_sm_out.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sm_out.sv
// FIR output stage: buffers Y results from the FIR core in a small FIFO and
// streams them out as an AXI-Stream master frame of data_length samples.
// A frame starts on a start pulse in IDLE and ends with a one-cycle DONE state.

module fir_sm_out #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [31:0]            data_length,
  input  logic                   y_valid,
  input  logic [pDATA_WIDTH-1:0] y_data,
  output logic                   y_ready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned Aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [Aw:0] FullCnt = (Aw + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q;
  logic [31:0]            len_q;
  logic [31:0]            in_cnt_q;
  logic [31:0]            out_cnt_q;
  logic [Aw-1:0]          wr_ptr_q;
  logic [Aw-1:0]          rd_ptr_q;
  logic [Aw:0]            occ_q;
  logic [pDATA_WIDTH-1:0] mem_q [DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Handshake and status outputs, all derived from registered state only
  always_comb begin
    fifo_full  = (occ_q == FullCnt);
    fifo_empty = (occ_q == '0);
    // No pass-through: a pop in the same cycle never frees a slot for a push
    y_ready    = (state_q == StRun) && !fifo_full && (in_cnt_q < len_q);
    sm_tvalid  = (state_q == StRun) && !fifo_empty;
    sm_tdata   = mem_q[rd_ptr_q];
    sm_tlast   = sm_tvalid && (out_cnt_q == len_q - 32'd1);
    push       = y_valid && y_ready;
    pop        = sm_tvalid && sm_tready;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

  // Frame FSM, transfer counters and FIFO pointers/occupancy
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            len_q     <= data_length;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            // A zero-length frame completes without touching the stream
            state_q   <= (data_length != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            in_cnt_q <= in_cnt_q + 32'd1;
          end
          if (pop) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            out_cnt_q <= out_cnt_q + 32'd1;
            if (sm_tlast) begin
              state_q <= StDone;
            end
          end
          if (push && !pop) begin
            occ_q <= occ_q + 1'b1;
          end else if (pop && !push) begin
            occ_q <= occ_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= y_data;
    end
  end

endmodule

// File: tb/tb_fir_sm_out.sv
// Directed bench for fir_sm_out: a table of frames applied by a common
// frame driver, plus hand-written zero-length and mid-frame reset sequences.

module tb_fir_sm_out;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          axis_clk = 1'b0;
  logic          axis_rst;
  logic          start;
  logic [31:0]   data_length;
  logic          y_valid;
  logic [DW-1:0] y_data;
  logic          y_ready;
  logic          sm_tready;
  logic          sm_tvalid;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          len;       // data_length for the frame
    int          nfeed;     // samples the FIR side offers
    logic [31:0] base;      // y value of the first sample, then +1 each
    int          ypct;      // y_valid probability in percent
    int          tpct;      // sm_tready probability in percent
    int          hold;      // initial cycles with sm_tready forced low
    int          start_at;  // cycle of an extra start pulse inside the frame (0 = none)
    int          exp_n;     // samples expected on the stream
  } frame_t;

  frame_t tbl[7];
  frame_t post_rst;

  always #5 axis_clk = ~axis_clk;

  fir_sm_out #(
    .pDATA_WIDTH(DW),
    .DEPTH      (DEPTH)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .start      (start),
    .data_length(data_length),
    .y_valid    (y_valid),
    .y_data     (y_data),
    .y_ready    (y_ready),
    .sm_tready  (sm_tready),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_y_ready"}, y_ready, 0);
    chk({tag, "_tvalid"}, sm_tvalid, 0);
    chk({tag, "_tlast"}, sm_tlast, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Drives one frame and checks every cycle against an occupancy model
  task automatic run_frame(input frame_t f);
    int          acc;
    int          outs;
    int          last_hs;
    int          occ;
    int          nbuf;
    bit          stall;
    bit          got_done;
    logic [31:0] pd;
    logic        pl;
    acc      = 0;
    outs     = 0;
    last_hs  = -10;
    stall    = 1'b0;
    got_done = 1'b0;
    pd       = '0;
    pl       = 1'b0;
    nbuf     = (f.len < DEPTH) ? f.len : DEPTH;
    @(posedge axis_clk); #1;
    start       = 1'b1;
    data_length = f.len;
    y_valid     = 1'b0;
    sm_tready   = 1'b0;
    @(posedge axis_clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      y_valid     = (acc < f.nfeed) && ($urandom_range(99) < f.ypct);
      y_data      = f.base + acc;
      sm_tready   = (cyc >= f.hold) && ($urandom_range(99) < f.tpct);
      start       = (f.start_at != 0) && (cyc == f.start_at);
      data_length = start ? 32'd99 : f.len;
      @(negedge axis_clk);
      occ = acc - outs;
      chk("y_ready", y_ready, (occ < DEPTH) && (acc < f.len));
      chk("tvalid", sm_tvalid, occ > 0);
      chk("tlast", sm_tlast, sm_tvalid && (outs == f.exp_n - 1));
      if (f.hold != 0 && cyc == f.hold) begin
        chk("buffered", acc, nbuf);
      end
      if (stall) begin
        chk("stall_valid", sm_tvalid, 1);
        chk("stall_data", sm_tdata, pd);
        chk("stall_last", sm_tlast, pl);
      end
      if (y_valid && y_ready) acc++;
      if (sm_tvalid && sm_tready) begin
        chk("data", sm_tdata, f.base + outs);
        outs++;
        last_hs = cyc;
      end
      stall = sm_tvalid && !sm_tready;
      pd    = sm_tdata;
      pl    = sm_tlast;
      chk("busy", busy, 1);
      if (done) begin
        got_done = 1'b1;
        chk("done_latency", cyc, last_hs + 1);
      end else begin
        @(posedge axis_clk); #1;
      end
    end
    chk("frame_done", got_done, 1);
    chk("out_count", outs, f.exp_n);
    chk("in_count", acc, f.exp_n);
    @(posedge axis_clk); #1;
    y_valid   = 1'b0;
    sm_tready = 1'b0;
    @(negedge axis_clk);
    chk_quiet("after_done");
  endtask

  initial begin
    int outs;
    int acc;

    //                len nfeed base           ypct tpct hold st  exp
    tbl[0] = '{len: 5,   nfeed: 5,   base: 32'd1,          ypct: 100, tpct: 100,
               hold: 0,  start_at: 0, exp_n: 5};
    tbl[1] = '{len: 8,   nfeed: 8,   base: 32'd11,         ypct: 100, tpct: 100,
               hold: 10, start_at: 0, exp_n: 8};
    tbl[2] = '{len: 3,   nfeed: 6,   base: 32'd21,         ypct: 100, tpct: 100,
               hold: 0,  start_at: 2, exp_n: 3};
    tbl[3] = '{len: 2,   nfeed: 2,   base: 32'hFFFF_FFFE,  ypct: 100, tpct: 100,
               hold: 0,  start_at: 0, exp_n: 2};
    tbl[4] = '{len: 1,   nfeed: 1,   base: 32'h8000_0000,  ypct: 100, tpct: 40,
               hold: 0,  start_at: 0, exp_n: 1};
    tbl[5] = '{len: 100, nfeed: 100, base: 32'd1000,       ypct: 100, tpct: 50,
               hold: 0,  start_at: 0, exp_n: 100};
    tbl[6] = '{len: 20,  nfeed: 20,  base: 32'd500,        ypct: 60,  tpct: 70,
               hold: 0,  start_at: 0, exp_n: 20};
    post_rst = '{len: 2, nfeed: 2,   base: 32'h200,        ypct: 100, tpct: 100,
               hold: 0,  start_at: 0, exp_n: 2};

    axis_rst    = 1'b1;
    start       = 1'b0;
    data_length = '0;
    y_valid     = 1'b0;
    y_data      = '0;
    sm_tready   = 1'b0;
    #3;
    chk_quiet("in_reset");
    @(posedge axis_clk); #1;
    @(posedge axis_clk); #1;
    axis_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_clk);
      chk_quiet("idle");
    end

    // Zero-length frame: DONE the cycle after start, stream untouched
    @(posedge axis_clk); #1;
    start       = 1'b1;
    data_length = 32'd0;
    @(negedge axis_clk);
    chk("zl_pre_done", done, 0);
    @(posedge axis_clk); #1;
    start = 1'b0;
    @(negedge axis_clk);
    chk("zl_done", done, 1);
    chk("zl_busy", busy, 1);
    chk("zl_tvalid", sm_tvalid, 0);
    chk("zl_y_ready", y_ready, 0);
    @(posedge axis_clk); #1;
    @(negedge axis_clk);
    chk_quiet("zl_after");

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i]);
    end

    // Reset in the middle of a 6-sample frame, after 2 samples have left
    @(posedge axis_clk); #1;
    start       = 1'b1;
    data_length = 32'd6;
    @(posedge axis_clk); #1;
    start = 1'b0;
    outs  = 0;
    acc   = 0;
    for (int cyc = 0; cyc < 50 && outs < 2; cyc++) begin
      y_valid   = 1'b1;
      y_data    = 32'h100 + acc;
      sm_tready = 1'b1;
      @(negedge axis_clk);
      if (y_valid && y_ready) acc++;
      if (sm_tvalid && sm_tready) outs++;
      if (outs < 2) begin
        @(posedge axis_clk); #1;
      end
    end
    chk("mr_outs", outs, 2);
    @(posedge axis_clk); #2;
    chk("mr_busy_before", busy, 1);
    chk("mr_tvalid_before", sm_tvalid, 1);
    axis_rst = 1'b1;
    #1;
    chk_quiet("mr_async");
    y_valid   = 1'b0;
    sm_tready = 1'b0;
    @(posedge axis_clk); #1;
    @(posedge axis_clk); #1;
    axis_rst  = 1'b0;
    sm_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_clk);
      chk_quiet("mr_idle");
    end
    sm_tready = 1'b0;
    run_frame(post_rst);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
